// File: rtl/des_output_serializer_pkg.sv
// rtl/des_output_serializer_pkg.sv - shared DES constants and serializer state type
package des_output_serializer_pkg;

    localparam int DES_BLOCK_W     = 64;
    localparam int DES_BLOCK_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/des_output_serializer_if.sv
// rtl/des_output_serializer_if.sv - DES controller result handshake and TX FIFO write port
interface des_output_serializer_if;
    import des_output_serializer_pkg::*;

    logic                   data_out;
    logic [DES_BLOCK_W-1:0] des_result;
    logic                   empty;
    logic                   fifo_full;
    logic                   fifo_wr;
    logic [7:0]             fifo_wdata;

    // master: the controller / FIFO side that feeds and drains the serializer
    modport master (
        output data_out, des_result, fifo_full,
        input  empty, fifo_wr, fifo_wdata
    );

    modport slave (
        input  data_out, des_result, fifo_full,
        output empty, fifo_wr, fifo_wdata
    );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - enable-gated counter wrapping to zero after rollover_val counts
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    // Flag marks the count that completes the run, so the owner can act on the same edge.
    assign rollover_flag = count_enable &&
                           (count_out == rollover_val - NUM_CNT_BITS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (rollover_flag) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/des_output_serializer.sv
// rtl/des_output_serializer.sv - serializes a captured DES result block MSB-first into the TX FIFO
module des_output_serializer
    import des_output_serializer_pkg::*;
#(
    parameter int BLOCK_BYTES = DES_BLOCK_BYTES,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    des_output_serializer_if.slave bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       blocks_sent
);

    localparam int              BC_W     = 4;
    localparam logic [BC_W-1:0] ROLLOVER = BC_W'(BLOCK_BYTES);

    ser_state_t             state;
    ser_state_t             next_state;
    logic [DES_BLOCK_W-1:0] shift_reg;
    logic                   capture;
    logic                   fifo_wr;
    logic                   last_byte;
    logic [BC_W-1:0]        byte_count_unused;

    assign fifo_wr         = (state == SEND) && !bus.fifo_full;
    assign bus.fifo_wr     = fifo_wr;
    assign bus.fifo_wdata  = (state == SEND) ? shift_reg[DES_BLOCK_W-1 -: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // empty stays low in the offer cycle so the controller cannot mistake it for consumption.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        busy       = 1'b0;
        bus.empty  = 1'b0;
        case (state)
            IDLE: begin
                bus.empty = !bus.data_out;
                if (bus.data_out) begin
                    capture    = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (last_byte) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.empty = 1'b1;
                if (!bus.data_out) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (capture) begin
            shift_reg <= bus.des_result;
        end else if (fifo_wr) begin
            shift_reg <= {shift_reg[DES_BLOCK_W-9:0], 8'h00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_sent <= '0;
        end else if (fifo_wr && last_byte) begin
            blocks_sent <= blocks_sent + CNT_W'(1);
        end
    end

    flex_counter #(
        .NUM_CNT_BITS(BC_W)
    ) u_byte_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (capture),
        .count_enable (fifo_wr),
        .rollover_val (ROLLOVER),
        .count_out    (byte_count_unused),
        .rollover_flag(last_byte)
    );

endmodule
